// File: rtl/instruction_loader.sv
`timescale 1ns/1ps
// instruction_loader
// Debug-side writer for the instruction memory's program-load port. Bytes
// arriving on rx_valid are assembled MSB-first into 32-bit words. Each word
// is written to consecutive word addresses starting at 0. A session ends on
// the terminator word, which is itself written, or when memory is full.
//
// Ports:
//   clk              system clock, rising edge
//   rst              synchronous active-high reset
//   start            begin a load session (honoured in IDLE and DONE only)
//   rx_data[7:0]     received byte
//   rx_valid         one-cycle strobe qualifying rx_data
//   wr_instruction   one-cycle write strobe to instruction memory
//   data_instruction word being written
//   inst_addr        word address (upper bits zero)
//   busy             session in progress (RECV or WRITE)
//   done             session finished; held until next start or rst
//   full             session ended because 2^ADDR_W words were written
//   word_count       words written this session
module instruction_loader #(
    parameter int unsigned ADDR_W    = 5,
    parameter logic [31:0] TERM_WORD = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              wr_instruction,
    output logic [31:0]       data_instruction,
    output logic [31:0]       inst_addr,
    output logic              busy,
    output logic              done,
    output logic              full,
    output logic [ADDR_W:0]   word_count
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    // Only the first three bytes need holding; the fourth goes straight
    // into the output word.
    logic [23:0]        asm_q, asm_d;
    logic [1:0]         byte_cnt_q, byte_cnt_d;
    logic [31:0]        data_q, data_d;
    // The session word count doubles as the write address: both clear on
    // start and advance together after every write.
    logic [CNT_W-1:0]   count_q, count_d;
    logic               wr_q, wr_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               full_q, full_d;

    logic [CNT_W-1:0]   count_inc;
    logic [31:0]        rx_word;
    logic               is_term;
    logic               hit_full;

    assign count_inc = count_q + CNT_W'(1);
    assign rx_word   = {asm_q, rx_data};
    assign is_term   = (data_q == TERM_WORD);
    assign hit_full  = (count_inc == CNT_W'(DEPTH));

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            asm_q      <= '0;
            byte_cnt_q <= '0;
            data_q     <= '0;
            count_q    <= '0;
            wr_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            full_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            asm_q      <= asm_d;
            byte_cnt_q <= byte_cnt_d;
            data_q     <= data_d;
            count_q    <= count_d;
            wr_q       <= wr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            full_q     <= full_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        asm_d      = asm_q;
        byte_cnt_d = byte_cnt_q;
        data_d     = data_q;
        count_d    = count_q;
        wr_d       = 1'b0;
        done_d     = done_q;
        full_d     = full_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = RECV;
                    asm_d      = '0;
                    byte_cnt_d = '0;
                    count_d    = '0;
                end
            end

            RECV: begin
                if (rx_valid) begin
                    asm_d = {asm_q[15:0], rx_data};
                    if (byte_cnt_q == 2'd3) begin
                        data_d     = rx_word;
                        wr_d       = 1'b1;
                        byte_cnt_d = '0;
                        state_d    = WRITE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
            end

            WRITE: begin
                count_d = count_inc;
                if (is_term || hit_full) begin
                    // A byte arriving now belongs to no session; drop it.
                    state_d = DONE;
                    done_d  = 1'b1;
                    full_d  = hit_full;
                end else begin
                    state_d = RECV;
                    // Back-to-back stream: this byte starts the next word.
                    if (rx_valid) begin
                        asm_d      = {asm_q[15:0], rx_data};
                        byte_cnt_d = 2'd1;
                    end
                end
            end

            DONE: begin
                if (start) begin
                    state_d    = RECV;
                    asm_d      = '0;
                    byte_cnt_d = '0;
                    count_d    = '0;
                    done_d     = 1'b0;
                    full_d     = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RECV) || (state_d == WRITE);
    end

    assign wr_instruction   = wr_q;
    assign data_instruction = data_q;
    assign inst_addr        = 32'(count_q);
    assign busy             = busy_q;
    assign done             = done_q;
    assign full             = full_q;
    assign word_count       = count_q;

endmodule

// File: doc/instruction_loader.md
# instruction_loader

Debug-side writer for the instruction memory's program-load port. Receives a byte stream (one byte per `rx_valid` strobe, typically from the debug UART receiver) and assembles MSB-first 32-bit instruction words. Writes each word into instruction memory via `wr_instruction` / `data_instruction` / `inst_addr` at consecutive word addresses starting at 0. Stops on a terminator word or when memory is full, then reports completion so the debug unit can release the pipeline.

## Interface
- `ADDR_W`, default 5: word-address width; memory depth is 2^ADDR_W words.
- `TERM_WORD`, default 32'hFFFF_FFFF: terminator instruction that ends a load session.

- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  begin a load session; sampled in IDLE and DONE only.
- `rx_data`  in  8  received byte.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` valid this cycle.
- `wr_instruction`  out  1  one-cycle write strobe to instruction memory.
- `data_instruction`  out  32  word being written.
- `inst_addr`  out  32  word address for instruction-memory `inAddr`; upper bits zero.
- `busy`  out  1  session in progress (RECV or WRITE).
- `done`  out  1  level; session finished; held until next `start` or `rst`.
- `full`  out  1  level; session ended because 2^ADDR_W words were written.
- `word_count`  out  ADDR_W+1  number of words written this session.

## Operation
- States: IDLE, RECV, WRITE, DONE.
- IDLE:
  - `start`=1 → RECV; address, byte counter and `word_count` cleared.
  - `rx_valid` is ignored.
- RECV:
  - On each `rx_valid`, shift the byte into the assembly register MSB-first: the first byte lands in [31:24].
  - On the 4th byte, latch the assembled word into `data_instruction` → WRITE.
- WRITE (exactly one cycle):
  - `wr_instruction`=1; `inst_addr` and `data_instruction` stable.
  - Next cycle: address +1 and `word_count` +1.
  - If the word equals TERM_WORD → DONE. The terminator is written to memory so the CPU halts on it.
  - Else, if new `word_count` equals 2^ADDR_W → DONE with `full`=1.
  - Else → RECV.
- `rx_valid` during WRITE:
  - If the next state is RECV, the byte is captured as byte 0 of the next word (byte counter = 1).
  - If the next state is DONE, the byte is dropped.
- If TERM_WORD is also the 2^ADDR_W-th word: `done`=1 and `full`=1.
- DONE:
  - `rx_valid` is ignored.
  - `start` → RECV: clears `done`, `full`, `word_count`; address restarts at 0.
- `start` while `busy` is ignored. Partial words are kept; no timeout.
- `inst_addr` never exceeds 2^ADDR_W−1 while `wr_instruction`=1.

## Timing
- Reset values: state IDLE; `wr_instruction`=0, `data_instruction`=0, `inst_addr`=0, `busy`=0, `done`=0, `full`=0, `word_count`=0; assembly register and byte counter 0.
- `rst` mid-session aborts immediately with no write strobe; words already written remain in memory.
- All outputs are registered on the rising edge. The instruction memory samples on the falling edge, so outputs are stable half a cycle before capture.
- Latency: 4th-byte `rx_valid` in cycle n → `wr_instruction`=1 in cycle n+1.
- `inst_addr` increments in cycle n+2.
- `done`, `full` and `busy`=0 take effect in cycle n+2 after a terminating write.
- `start` in cycle n → `busy`=1 in cycle n+1.
- Back-to-back `rx_valid` every cycle is supported with no byte loss, including the WRITE-cycle case.

## Test plan
- **Reset:** assert `rst` for 2 cycles → all outputs 0, state IDLE. Send 4 bytes without `start` → no `wr_instruction`.
- **Basic load:** `start`, then bytes 20,01,00,08 followed by FF,FF,FF,FF.
  - Write 32'h2001_0008 at `inst_addr` 0.
  - Write 32'hFFFF_FFFF at `inst_addr` 1.
  - Then `done`=1, `full`=0, `word_count`=2, `busy`=0.
- **Continuous stream:** `rx_valid` every cycle for 12 bytes (3 non-terminator words) → 3 write strobes at addresses 0,1,2 with correct data; no byte dropped across WRITE cycles.
- **Full:** ADDR_W=2, 4 non-terminator words → writes at 0..3, then `done`=1, `full`=1, `word_count`=4. A 5th word is ignored.
- **Mid-session reset and restart:**
  - Assert `rst` after 6 bytes → no 2nd write, outputs at reset values.
  - New `start` plus 4 bytes → write at `inst_addr` 0.
- **Start while busy and reload:**
  - `start` during RECV is ignored and the byte count is preserved.
  - After `done`, `start` clears `done` and the next word writes at address 0.
